// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg : constants shared by the memory responder and the cache fill FSMs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_pkg;

  localparam logic [1:0] MEM_IDLE = 2'd0;
  localparam logic [1:0] MEM_RD   = 2'd1;
  localparam logic [1:0] MEM_WR   = 2'd2;

  // Fill counters in the caches are sized from this, so it must match LAT here
  localparam int MEM_LAT    = 4;
  localparam int MEM_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = MEM_IDLE,
    ST_RD   = MEM_RD,
    ST_WR   = MEM_WR
  } mem_state_e;

endpackage

`default_nettype wire

// File: rtl/mem_latency_pipe.sv
// ---------------------------------------------------------------------------
// mem_latency_pipe : STAGES-deep {valid, word address} shift register
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_latency_pipe
  import mem_pkg::*;
#(
  parameter int STAGES = MEM_LAT - 1,
  parameter int AW     = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  output logic          out_valid,
  output logic [AW-1:0] out_addr,
  output logic          any_valid,
  output logic          flush
);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [AW-1:0]     addr_q [STAGES];
  logic [AW-1:0]     addr_d [STAGES];

  always_comb begin
    valid_d[0] = in_valid;
    addr_d[0]  = in_addr;
    for (int i = 1; i < STAGES; i++) begin
      valid_d[i] = valid_q[i-1];
      addr_d[i]  = addr_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < STAGES; i++) addr_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < STAGES; i++) addr_q[i] <= addr_d[i];
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out_addr  = addr_q[STAGES-1];
  assign any_valid = |valid_q;
  // Reset discards every in-flight read; downstream uses this to suppress output
  assign flush     = rst;

endmodule

`default_nettype wire

// File: rtl/multi_cycle_mem_responder.sv
// ---------------------------------------------------------------------------
// multi_cycle_mem_responder : backing store with pipelined reads and blocking writes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multi_cycle_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = MEM_DATA_W,
  parameter int LAT    = MEM_LAT,
  parameter int DEPTH  = 65536 >> 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic              we,
  output logic [DATA_W-1:0] rdata,
  output logic              data_valid,
  output logic              wdone,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LAT);

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              data_valid_q, data_valid_d;
  logic              wdone_q, wdone_d;

  logic [DATA_W-1:0] mem_array [DEPTH];

  logic [IDX_W-1:0]  req_idx;
  logic              rd_accept;
  logic              wr_commit;
  logic              pipe_valid;
  logic [IDX_W-1:0]  pipe_addr;
  logic              pipe_any_valid;
  logic              pipe_flush;
  logic              unused_addr_lsb;

  assign req_idx         = addr[IDX_W:1];
  assign unused_addr_lsb = addr[0];
  assign rd_accept       = re && (state_q != ST_WR);
  assign wr_commit       = (state_q == ST_WR) && (cnt_q == '0);

  // The output register is the last latency stage, so the pipe holds LAT-1
  mem_latency_pipe #(
    .STAGES (LAT - 1),
    .AW     (IDX_W)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_accept),
    .in_addr   (req_idx),
    .out_valid (pipe_valid),
    .out_addr  (pipe_addr),
    .any_valid (pipe_any_valid),
    .flush     (pipe_flush)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    wdone_d      = 1'b0;
    data_valid_d = pipe_valid && !pipe_flush;
    rdata_d      = data_valid_d ? mem_array[pipe_addr] : '0;

    case (state_q)
      ST_IDLE: begin
        if (re) begin
          state_d = ST_RD;
        end else if (we) begin
          state_d = ST_WR;
          cnt_d   = CNT_W'(LAT - 1);
          waddr_d = req_idx;
          wdata_d = wdata;
        end
      end
      ST_RD: begin
        // Stay while new reads arrive or older ones are still in the pipe
        if (!re && !pipe_any_valid) state_d = ST_IDLE;
      end
      ST_WR: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          wdone_d = (cnt_q == CNT_W'(1));
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      data_valid_q <= 1'b0;
      wdone_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      data_valid_q <= data_valid_d;
      wdone_q      <= wdone_d;
    end
  end

  // Storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (wr_commit) mem_array[waddr_q] <= wdata_q;
  end

  assign rdata      = rdata_q;
  assign data_valid = data_valid_q;
  assign wdone      = wdone_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_multi_cycle_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_multi_cycle_mem_responder : directed + random checks against a cycle-schedule model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_multi_cycle_mem_responder;

  localparam int LAT = 4;
  localparam int N   = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [15:0] rdata;
  logic        data_valid;
  logic        wdone;
  logic        busy;

  multi_cycle_mem_responder #(
    .ADDR_W (16),
    .DATA_W (16),
    .LAT    (LAT),
    .DEPTH  (65536 >> 1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .wdata      (wdata),
    .re         (re),
    .we         (we),
    .rdata      (rdata),
    .data_valid (data_valid),
    .wdone      (wdone),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wr_accepts = 0;

  // Expected outputs per cycle, filled in when requests are accepted
  bit          exp_dv   [N];
  logic [15:0] exp_rd   [N];
  bit          exp_wd   [N];
  bit          exp_busy [N];
  bit          in_wr    [N];
  logic [15:0] mm [int];
  bit          pend_v = 0;
  int          pend_cyc, pend_idx;
  logic [15:0] pend_data;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdata"}, rdata, 16'h0);
    chk({tag, "_dv"}, {15'd0, data_valid}, 16'h0);
    chk({tag, "_wdone"}, {15'd0, wdone}, 16'h0);
    chk({tag, "_busy"}, {15'd0, busy}, 16'h0);
  endtask

  // One clock cycle: drive, check at negedge, update model, advance
  task automatic step(input bit r, input bit w, input logic [15:0] a, input logic [15:0] d);
    int idx;
    re = r; we = w; addr = a; wdata = d;
    @(negedge clk);
    chk("data_valid", {15'd0, data_valid}, {15'd0, exp_dv[cyc]});
    chk("rdata", rdata, exp_dv[cyc] ? exp_rd[cyc] : 16'h0);
    chk("wdone", {15'd0, wdone}, {15'd0, exp_wd[cyc]});
    chk("busy", {15'd0, busy}, {15'd0, exp_busy[cyc]});
    idx = int'(a >> 1);
    if (r && !in_wr[cyc]) begin
      exp_dv[cyc+LAT] = 1'b1;
      exp_rd[cyc+LAT] = mm.exists(idx) ? mm[idx] : 16'hxxxx;
      for (int k = 1; k <= LAT; k++) exp_busy[cyc+k] = 1'b1;
    end else if (w && !r && !exp_busy[cyc]) begin
      for (int k = 1; k <= LAT; k++) begin
        exp_busy[cyc+k] = 1'b1;
        in_wr[cyc+k]    = 1'b1;
      end
      exp_wd[cyc+LAT] = 1'b1;
      pend_v = 1'b1; pend_cyc = cyc + LAT; pend_idx = idx; pend_data = d;
      wr_accepts++;
    end
    if (pend_v && pend_cyc == cyc) begin
      mm[pend_idx] = pend_data;
      pend_v = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  // Requester behaviour: hold we until the cycle carrying wdone
  task automatic hold_write(input logic [15:0] a, input logic [15:0] d);
    int  start = wr_accepts;
    bit  done  = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      done = (wr_accepts > start) && exp_wd[cyc];
      step(1'b0, 1'b1, a, d);
    end
    n_checks++;
    assert (done) else begin
      n_fail++;
      $error("FAIL hold_write_timeout addr=%h observed=no_wdone expected=wdone", a);
    end
  endtask

  task automatic do_reset();
    re = 1'b0; we = 1'b0;
    rst = 1'b1;
    #2;
    chk_all_zero("reset_async");
    @(negedge clk);
    chk_all_zero("reset_hold");
    for (int i = cyc; i < N; i++) begin
      exp_dv[i] = 0; exp_wd[i] = 0; exp_busy[i] = 0; in_wr[i] = 0;
    end
    pend_v = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
  endtask

  initial begin
    logic [15:0] pool [8];
    bit r, w;

    #1 rst = 1'b1;
    #2 chk_all_zero("reset_init");
    @(posedge clk);
    #1 rst = 1'b0;
    cyc = 0;

    // Preload the fill line and scratch words through the write port
    for (int i = 0; i < 8; i++) begin
      pool[i] = 16'h1230 + 16'(2 * i);
      hold_write(pool[i], 16'hA918 + 16'(i));
    end
    hold_write(16'h0050, 16'h4444);
    idle(2);

    // Streamed line fill
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, pool[i], 16'h0);
    idle(LAT + 2);

    // Write then read back
    hold_write(16'h0040, 16'hBEEF);
    step(1'b1, 1'b0, 16'h0040, 16'h0);
    idle(LAT + 1);

    // Held we: two writes back to back
    hold_write(16'h0010, 16'h1111);
    hold_write(16'h0012, 16'h2222);
    step(1'b1, 1'b0, 16'h0010, 16'h0);
    step(1'b1, 1'b0, 16'h0012, 16'h0);
    idle(LAT + 1);

    // re and we together: reads win, write waits for the drain
    step(1'b1, 1'b1, 16'h0050, 16'h5555);
    step(1'b1, 1'b1, 16'h0050, 16'h5555);
    hold_write(16'h0050, 16'h5555);
    step(1'b1, 1'b0, 16'h0050, 16'h0);
    idle(LAT + 1);

    // Reset with three reads in flight
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, pool[i], 16'h0);
    do_reset();
    idle(LAT + 2);
    step(1'b1, 1'b0, pool[0], 16'h0);
    idle(LAT + 1);

    // Address wrap and byte-offset alignment
    hold_write(16'hFFFE, 16'h7E7E);
    step(1'b1, 1'b0, 16'hFFFF, 16'h0);
    idle(LAT + 1);
    hold_write(16'h0003, 16'h3333);
    step(1'b1, 1'b0, 16'h0002, 16'h0);
    step(1'b1, 1'b0, 16'h0003, 16'h0);
    idle(LAT + 1);

    // Random traffic over the preloaded words; re is never raised during a write
    for (int i = 0; i < 400; i++) begin
      r = in_wr[cyc] ? 1'b0 : 1'($urandom_range(0, 1));
      w = in_wr[cyc] ? 1'b1 : ($urandom_range(0, 2) == 0);
      step(r, w, pool[$urandom_range(0, 7)] | 16'($urandom_range(0, 1)), 16'($urandom));
    end
    idle(2 * LAT + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
